eif_spike_monitor: RTL

//   Downstream consumer of the EIF neuron's spike output (uio_out[7]). Detects spike

---
 rtl/eif_spike_monitor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/eif_spike_monitor.sv
//==============================================================================
// Module : eif_spike_monitor
// Brief  : Spike edge detector, inter-spike interval timer with valid/ready
//          output slot, burst flag and windowed firing-rate counter.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module eif_spike_monitor #(
  parameter int CNT_W     = 16,
  parameter int RATE_W    = 8,
  parameter int WINDOW    = 1000,
  parameter int BURST_THR = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clr,
  input  logic              spike_in,
  output logic [CNT_W-1:0]  isi_out,
  output logic              isi_valid,
  input  logic              isi_ready,
  output logic              isi_ovf,
  output logic [RATE_W-1:0] rate_out,
  output logic              rate_valid,
  output logic              burst
);

  localparam int                c_WIN_W      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int                c_CMP_W      = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [c_WIN_W-1:0] c_WIN_LAST  = c_WIN_W'(WINDOW - 1);
  localparam logic [c_WIN_W-1:0] c_WIN_ONE   = c_WIN_W'(1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  c_CNT_ONE    = CNT_W'(1);
  localparam logic [RATE_W-1:0] c_RATE_MAX   = {RATE_W{1'b1}};
  localparam logic [RATE_W-1:0] c_RATE_ONE   = RATE_W'(1);
  localparam logic [c_CMP_W-1:0] c_BURST_THR = c_CMP_W'(BURST_THR);

  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_TIMING = 1'b1;

  logic [0:0]         r_state;
  logic               r_spike_q;
  logic [CNT_W-1:0]   r_isi_cnt;
  logic [c_WIN_W-1:0] r_win_cnt;
  logic [RATE_W-1:0]  r_spk_cnt;
  logic [CNT_W-1:0]   r_isi_out;
  logic               r_isi_valid;
  logic               r_isi_ovf;
  logic [RATE_W-1:0]  r_rate_out;
  logic               r_rate_valid;
  logic               r_burst;

  logic               w_edge;
  logic               w_run;
  logic               w_capture;
  logic               w_slot_free;
  logic               w_win_end;
  logic               w_is_burst;
  logic [CNT_W-1:0]   w_isi_next;
  logic [RATE_W-1:0]  w_spk_next;

  assign w_edge      = spike_in & ~r_spike_q;
  assign w_run       = ena & ~clr;
  assign w_capture   = w_run & w_edge & (r_state == c_TIMING);
  assign w_slot_free = ~r_isi_valid | isi_ready;
  assign w_win_end   = (r_win_cnt == c_WIN_LAST);
  assign w_is_burst  = (c_CMP_W'(r_isi_cnt) < c_BURST_THR);
  assign w_isi_next  = (r_isi_cnt == c_CNT_MAX) ? r_isi_cnt : r_isi_cnt + c_CNT_ONE;
  assign w_spk_next  = (w_edge && (r_spk_cnt != c_RATE_MAX)) ? r_spk_cnt + c_RATE_ONE
                                                              : r_spk_cnt;

  // Edge history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike_q <= 1'b0;
    end else if (ena) begin
      r_spike_q <= clr ? 1'b0 : spike_in;
    end
  end

  // Interval FSM: the counter holds the cycle distance since the last edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_isi_cnt <= '0;
    end else if (ena) begin
      if (clr) begin
        r_state   <= c_IDLE;
        r_isi_cnt <= '0;
      end else if (r_state == c_IDLE) begin
        if (w_edge) begin
          r_state   <= c_TIMING;
          r_isi_cnt <= c_CNT_ONE;
        end
      end else if (w_edge) begin
        r_isi_cnt <= c_CNT_ONE;
      end else begin
        r_isi_cnt <= w_isi_next;
      end
    end
  end

  // Output slot; the handshake keeps draining even while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isi_out   <= '0;
      r_isi_valid <= 1'b0;
      r_isi_ovf   <= 1'b0;
      r_burst     <= 1'b0;
    end else if (ena && clr) begin
      r_isi_valid <= 1'b0;
      r_isi_ovf   <= 1'b0;
    end else begin
      if (r_isi_valid && isi_ready) begin
        r_isi_valid <= 1'b0;
      end
      if (w_capture) begin
        if (w_slot_free) begin
          r_isi_out   <= r_isi_cnt;
          r_isi_valid <= 1'b1;
          r_burst     <= w_is_burst;
        end else begin
          r_isi_ovf   <= 1'b1;
        end
      end
    end
  end

  // Rate window; the final-cycle edge is folded into the reported count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt    <= '0;
      r_spk_cnt    <= '0;
      r_rate_out   <= '0;
      r_rate_valid <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        r_win_cnt    <= '0;
        r_spk_cnt    <= '0;
        r_rate_valid <= 1'b0;
      end else if (w_win_end) begin
        r_win_cnt    <= '0;
        r_spk_cnt    <= '0;
        r_rate_out   <= w_spk_next;
        r_rate_valid <= 1'b1;
      end else begin
        r_win_cnt    <= r_win_cnt + c_WIN_ONE;
        r_spk_cnt    <= w_spk_next;
        r_rate_valid <= 1'b0;
      end
    end
  end

  assign isi_out    = r_isi_out;
  assign isi_valid  = r_isi_valid;
  assign isi_ovf    = r_isi_ovf;
  assign rate_out   = r_rate_out;
  assign rate_valid = r_rate_valid;
  assign burst      = r_burst;

endmodule

`default_nettype wire
